// File: rtl/hwpe_stream_packer_if.sv
// Valid/ready stream bundle with per-byte strobe, shared by the packer's narrow input and wide output.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, output data, output strb, input  ready);
   modport sink   (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_packer.sv
// Packs RATIO narrow stream beats into one wide strobed beat; flush_i emits a masked partial word.
// Define HWPE_STREAM_PACKER_MSB_FIRST_EN to fill lanes from RATIO-1 down to 0 instead of 0 upward.
module hwpe_stream_packer #(
   parameter int unsigned DATA_WIDTH_IN = 32,
   parameter int unsigned RATIO         = 4,
   parameter int unsigned CNT_WIDTH     = $clog2(RATIO)+1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  flush_i,
   hwpe_stream_intf_stream.sink   push_i,
   hwpe_stream_intf_stream.source pop_o,
   output logic [CNT_WIDTH-1:0]  fill_o,
   output logic                  busy_o
);

   localparam int unsigned          STRB_IN = DATA_WIDTH_IN/8;
   localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(RATIO-1);

   typedef logic [RATIO-1:0][DATA_WIDTH_IN-1:0] word_t;
   typedef logic [RATIO-1:0][STRB_IN-1:0]       wstrb_t;

   word_t                acc_data, acc_data_n, out_data;
   wstrb_t               acc_strb, acc_strb_n, out_strb;
   logic [CNT_WIDTH-1:0] cnt, lane;
   logic                 out_valid, pending;
   logic                 out_free, push_ready, hs, complete, flush_req, emit;

   assign out_free   = ~out_valid | pop_o.ready;
   // A pending flush freezes the accumulator until its partial word leaves.
   assign push_ready = ~pending & (out_free | (cnt != LAST));
   assign hs         = push_i.valid & push_ready;
   assign complete   = hs & (cnt == LAST);
   assign flush_req  = flush_i & ((cnt != '0) | hs);
   assign emit       = complete | (out_free & (flush_req | pending));

`ifdef HWPE_STREAM_PACKER_MSB_FIRST_EN
   assign lane = LAST - cnt;
`else
   assign lane = cnt;
`endif

   // Next accumulator image, including this cycle's incoming lane.
   for (genvar i = 0; i < RATIO; i++) begin : g_lane
      logic sel;
      assign sel           = hs & (lane == CNT_WIDTH'(i));
      assign acc_data_n[i] = sel ? push_i.data : acc_data[i];
      assign acc_strb_n[i] = sel ? push_i.strb : acc_strb[i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt       <= '0;
         acc_data  <= '0;
         acc_strb  <= '0;
         out_data  <= '0;
         out_strb  <= '0;
         out_valid <= 1'b0;
         pending   <= 1'b0;
      end else if (clear_i) begin
         cnt       <= '0;
         acc_data  <= '0;
         acc_strb  <= '0;
         out_data  <= '0;
         out_strb  <= '0;
         out_valid <= 1'b0;
         pending   <= 1'b0;
      end else if (emit) begin
         // Zeroed accumulator leaves unfilled lanes masked on the next partial word.
         out_data  <= acc_data_n;
         out_strb  <= acc_strb_n;
         out_valid <= 1'b1;
         acc_data  <= '0;
         acc_strb  <= '0;
         cnt       <= '0;
         pending   <= 1'b0;
      end else begin
         if (pop_o.ready) out_valid <= 1'b0;
         acc_data <= acc_data_n;
         acc_strb <= acc_strb_n;
         if (hs) cnt <= cnt + CNT_WIDTH'(1);
         if (flush_req) pending <= 1'b1;
      end
   end

   assign push_i.ready = push_ready;
   assign pop_o.valid  = out_valid;
   assign pop_o.data   = out_data;
   assign pop_o.strb   = out_strb;
   assign fill_o       = cnt;
   assign busy_o       = (cnt != '0) | out_valid | pending;

endmodule

// File: tb/tb_hwpe_stream_packer.sv
// Directed bench for hwpe_stream_packer; a scoreboard queue holds the expected wide beats.
module tb_hwpe_stream_packer;
   localparam int DW = 32;
   localparam int R  = 4;
   localparam int OW = DW*R;
   localparam int CW = $clog2(R)+1;

   typedef struct packed {
      logic [OW-1:0]   d;
      logic [OW/8-1:0] s;
   } beat_t;

   logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, flush = 1'b0;
   logic [CW-1:0] fill;
   logic          busy;
   int            n_chk = 0, n_pass = 0;
   beat_t         exp_q[$];
   logic          held = 1'b0;
   beat_t         last;

   always #5 clk = ~clk;

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(OW)) pop_if ();

   hwpe_stream_packer #(.DATA_WIDTH_IN(DW), .RATIO(R), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .flush_i(flush),
      .push_i(push_if), .pop_o(pop_if), .fill_o(fill), .busy_o(busy)
   );

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Expected words are written in lane-0-first order; the MSB-first build mirrors the lanes.
   function automatic beat_t mk(input logic [OW-1:0] d, input logic [OW/8-1:0] s);
      beat_t b;
`ifdef HWPE_STREAM_PACKER_MSB_FIRST_EN
      for (int i = 0; i < R; i++) begin
         b.d[i*DW +: DW]       = d[(R-1-i)*DW +: DW];
         b.s[i*DW/8 +: DW/8]   = s[(R-1-i)*DW/8 +: DW/8];
      end
`else
      b.d = d;
      b.s = s;
`endif
      return b;
   endfunction

   task automatic enq(input logic [OW-1:0] d, input logic [OW/8-1:0] s);
      exp_q.push_back(mk(d, s));
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic do_push(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic fl);
      int t;
      push_if.valid = 1'b1; push_if.data = d; push_if.strb = s; flush = fl;
      t = 0;
      do begin @(negedge clk); t++; end while (!push_if.ready && t < 50);
      if (!push_if.ready) begin
         n_chk++;
         $display("FAIL push_timeout: ready low for %0d cycles, expected high", t);
      end
      tick();
      push_if.valid = 1'b0; flush = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks stall stability.
   initial begin
      forever begin
         @(negedge clk);
         if (held && pop_if.valid) begin
            chk("hold_data", pop_if.data, last.d);
            chk("hold_strb", OW'(pop_if.strb), OW'(last.s));
         end
         if (pop_if.valid && pop_if.ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_beat: got data %0h, expected no beat", pop_if.data);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("pop_data", pop_if.data, e.d);
               chk("pop_strb", OW'(pop_if.strb), OW'(e.s));
            end
         end
         held   = pop_if.valid && !pop_if.ready;
         last.d = pop_if.data;
         last.s = pop_if.strb;
      end
   end

   initial begin
      push_if.valid = 1'b0; push_if.data = '0; push_if.strb = '0; pop_if.ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", OW'(pop_if.valid), 0);
      chk("rst_fill",  OW'(fill), 0);
      chk("rst_busy",  OW'(busy), 0);
      chk("rst_ready", OW'(push_if.ready), 1);

      // full word, output ready
      tick();
      pop_if.ready = 1'b1;
      enq(128'h44444444_33333333_22222222_11111111, 16'hFFFF);
      do_push(32'h11111111, 4'hF, 0);
      do_push(32'h22222222, 4'hF, 0);
      do_push(32'h33333333, 4'hF, 0);
      do_push(32'h44444444, 4'hF, 0);
      @(negedge clk);
      chk("full_valid", OW'(pop_if.valid), 1);
      chk("full_fill",  OW'(fill), 0);
      tick();

      // partial flush
      enq(128'h00000000_00000000_BBBBBBBB_AAAAAAAA, 16'h00FF);
      do_push(32'hAAAAAAAA, 4'hF, 0);
      do_push(32'hBBBBBBBB, 4'hF, 0);
      flush = 1'b1; tick(); flush = 1'b0;
      @(negedge clk);
      chk("flush_valid", OW'(pop_if.valid), 1);
      chk("flush_fill",  OW'(fill), 0);
      tick();

      // backpressure
      pop_if.ready = 1'b0;
      enq(128'h04040404_03030303_02020202_01010101, 16'hFFFF);
      enq(128'h08080808_07070707_06060606_05050505, 16'hFFFF);
      for (int i = 1; i <= 7; i++) do_push({4{8'(i)}}, 4'hF, 0);
      @(negedge clk);
      chk("bp_fill",  OW'(fill), 3);
      chk("bp_valid", OW'(pop_if.valid), 1);
      tick();
      push_if.valid = 1'b1; push_if.data = 32'h08080808; push_if.strb = 4'hF;
      repeat (2) begin
         @(negedge clk);
         chk("bp_stall_ready", OW'(push_if.ready), 0);
         tick();
      end
      pop_if.ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", OW'(push_if.ready), 1);
      tick();
      push_if.valid = 1'b0;
      @(negedge clk);
      chk("bp_word2_valid", OW'(pop_if.valid), 1);
      tick();

      // flush while the output is blocked
      pop_if.ready = 1'b0;
      enq(128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909, 16'hFFFF);
      enq(128'h00000000_00000000_0E0E0E0E_0D0D0D0D, 16'h00FF);
      for (int i = 9; i <= 14; i++) do_push({4{8'(i)}}, 4'hF, 0);
      flush = 1'b1; tick(); flush = 1'b0;
      @(negedge clk);
      chk("pend_ready", OW'(push_if.ready), 0);
      chk("pend_busy",  OW'(busy), 1);
      chk("pend_fill",  OW'(fill), 2);
      tick();
      pop_if.ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("pend_partial_valid", OW'(pop_if.valid), 1);
      chk("pend_fill_after",    OW'(fill), 0);
      tick();

      // flush with a same-cycle push, partial input strobe
      enq(128'h00000000_00000000_1E1E1E1E_0F0F0F0F, 16'h00F3);
      do_push(32'h0F0F0F0F, 4'h3, 0);
      do_push(32'h1E1E1E1E, 4'hF, 1);
      @(negedge clk);
      chk("same_cycle_valid", OW'(pop_if.valid), 1);
      tick();

      // clear mid-operation
      pop_if.ready = 1'b0;
      for (int i = 33; i <= 39; i++) do_push({4{8'(i)}}, 4'hF, 0);
      @(negedge clk);
      chk("clr_pre_fill",  OW'(fill), 3);
      chk("clr_pre_valid", OW'(pop_if.valid), 1);
      tick();
      clear = 1'b1; tick(); clear = 1'b0;
      @(negedge clk);
      chk("clr_valid", OW'(pop_if.valid), 0);
      chk("clr_fill",  OW'(fill), 0);
      chk("clr_busy",  OW'(busy), 0);
      tick();
      pop_if.ready = 1'b1;
      enq(128'h00000000_00000000_6B6B6B6B_5A5A5A5A, 16'h00FF);
      do_push(32'h5A5A5A5A, 4'hF, 0);
      do_push(32'h6B6B6B6B, 4'hF, 1);
      repeat (4) tick();
      chk("queue_empty", OW'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
